// File: rtl/free_list_if.sv
// Rename/commit-side bus of the physical-register free list.
// Ports (slave view, i.e. the free list):
//   in : alloc_req, checkpoint_valid, checkpoint_tag, free_valid, free_preg,
//        branch_shootdown, shootdown_branch_tag
//   out: alloc_valid, alloc_preg, alloc_fire, free_count, error
interface free_list_if #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned TAG_W     = 3
);
    localparam int unsigned PREG_W = $clog2(NUM_PREGS);

    logic              alloc_req;
    logic              alloc_valid;
    logic [PREG_W-1:0] alloc_preg;
    logic              alloc_fire;
    logic              checkpoint_valid;
    logic [TAG_W-1:0]  checkpoint_tag;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic              branch_shootdown;
    logic [TAG_W-1:0]  shootdown_branch_tag;
    logic [PREG_W:0]   free_count;
    logic              error;

    // Rename / commit / branch-unit side
    modport master (
        output alloc_req, checkpoint_valid, checkpoint_tag, free_valid, free_preg,
               branch_shootdown, shootdown_branch_tag,
        input  alloc_valid, alloc_preg, alloc_fire, free_count, error
    );

    // Free list side
    modport slave (
        input  alloc_req, checkpoint_valid, checkpoint_tag, free_valid, free_preg,
               branch_shootdown, shootdown_branch_tag,
        output alloc_valid, alloc_preg, alloc_fire, free_count, error
    );
endinterface

// File: rtl/free_list.sv
// Physical-register free list for the rename stage.
// Circular buffer of free pregs with a head (allocate) and tail (reclaim)
// pointer, each carrying a wrap bit. The head is checkpointed per branch tag
// so a shootdown returns all pregs allocated on the killed path in one cycle.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : alloc_req/alloc_valid/alloc_preg/alloc_fire,
//                     checkpoint_valid/checkpoint_tag, free_valid/free_preg,
//                     branch_shootdown/shootdown_branch_tag, free_count, error
module free_list #(
    parameter int unsigned NUM_PREGS              = 64,
    parameter int unsigned NUM_AREGS              = 32,
    parameter int unsigned MAX_PREDICT_DEPTH      = 4,
    parameter int unsigned MAX_PREDICT_DEPTH_BITS = 3
) (
    input  logic      clk,
    input  logic      reset,
    free_list_if.slave bus
);
    localparam int unsigned PREG_W   = $clog2(NUM_PREGS);
    localparam int unsigned PTR_W    = PREG_W + 1;
    localparam int unsigned TAG_W    = MAX_PREDICT_DEPTH_BITS;
    localparam int unsigned NUM_INIT = NUM_PREGS - NUM_AREGS;

    logic [PREG_W-1:0]            mem [NUM_PREGS];
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [PTR_W-1:0]             ckpt_ptr [MAX_PREDICT_DEPTH];
    logic [MAX_PREDICT_DEPTH-1:0] ckpt_valid;
    logic                         error_q;

    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] head_alloc;
    logic [PTR_W-1:0] sd_head;
    logic             list_empty;
    logic             list_full;
    logic             fire;
    logic             sd_ok;
    logic             ckpt_ok;
    logic             free_ok;
    logic             err_next;

    // Occupancy, handshake and legality of this cycle's requests
    always_comb begin
        count      = tail - head;
        list_empty = (head == tail);
        list_full  = (count == PTR_W'(NUM_PREGS));
        fire       = bus.alloc_req & ~list_empty & ~bus.branch_shootdown;
        head_alloc = head + PTR_W'(fire);
        ckpt_ok    = (bus.checkpoint_tag != '0) &&
                     (bus.checkpoint_tag <= TAG_W'(MAX_PREDICT_DEPTH));
        sd_ok      = 1'b0;
        sd_head    = head;
        for (int i = 0; i < int'(MAX_PREDICT_DEPTH); i++) begin
            if (bus.shootdown_branch_tag == TAG_W'(i + 1) && ckpt_valid[i]) begin
                sd_ok   = 1'b1;
                sd_head = ckpt_ptr[i];
            end
        end
        free_ok  = bus.free_valid & ~list_full;
        // A checkpoint alongside a shootdown is ignored, so it cannot be illegal
        err_next = (bus.free_valid & list_full) |
                   (bus.branch_shootdown & ~sd_ok) |
                   (~bus.branch_shootdown & bus.checkpoint_valid & ~ckpt_ok);
    end

    assign bus.alloc_valid = ~list_empty;
    assign bus.alloc_preg  = mem[head[PREG_W-1:0]];
    assign bus.alloc_fire  = fire;
    assign bus.free_count  = count;
    assign bus.error       = error_q;

    // Buffer, pointers and checkpoint slots
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_PREGS); i++) begin
                mem[i] <= (i < int'(NUM_INIT)) ? PREG_W'(i + int'(NUM_AREGS)) : '0;
            end
            for (int i = 0; i < int'(MAX_PREDICT_DEPTH); i++) begin
                ckpt_ptr[i] <= '0;
            end
            head       <= '0;
            tail       <= PTR_W'(NUM_INIT);
            ckpt_valid <= '0;
            error_q    <= 1'b0;
        end else begin
            error_q <= err_next;
            // Frees proceed regardless of any shootdown
            if (free_ok) begin
                mem[tail[PREG_W-1:0]] <= bus.free_preg;
                tail                  <= tail + PTR_W'(1);
            end
            if (bus.branch_shootdown) begin
                if (sd_ok) begin
                    head <= sd_head;
                    // Killed tag and every younger one
                    for (int i = 0; i < int'(MAX_PREDICT_DEPTH); i++) begin
                        if (TAG_W'(i + 1) >= bus.shootdown_branch_tag) begin
                            ckpt_valid[i] <= 1'b0;
                        end
                    end
                end
            end else begin
                head <= head_alloc;
                // Post-allocation head: same-cycle allocation belongs to the older path
                if (bus.checkpoint_valid && ckpt_ok) begin
                    for (int i = 0; i < int'(MAX_PREDICT_DEPTH); i++) begin
                        if (bus.checkpoint_tag == TAG_W'(i + 1)) begin
                            ckpt_ptr[i]   <= head_alloc;
                            ckpt_valid[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_free_list.sv
// Testbench for free_list: directed scenarios plus randomized traffic checked
// against a reference model that keeps every freed preg in an unbounded log
// indexed by absolute allocation/free counts.
module tb_free_list;
    localparam int NP    = 64;
    localparam int NA    = 32;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    free_list_if #(.NUM_PREGS(NP), .TAG_W(3)) bus ();

    free_list #(
        .NUM_PREGS(NP), .NUM_AREGS(NA),
        .MAX_PREDICT_DEPTH(DEPTH), .MAX_PREDICT_DEPTH_BITS(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: absolute counters, no wrap arithmetic
    int log_q[$];
    int m_head;
    int m_tail;
    int m_cp[DEPTH];
    bit m_cv[DEPTH];
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        log_q.delete();
        for (int i = 0; i < NP - NA; i++) log_q.push_back(NA + i);
        m_head = 0;
        m_tail = NP - NA;
        for (int i = 0; i < DEPTH; i++) m_cv[i] = 1'b0;
        m_err = 1'b0;
    endfunction

    // One clock cycle: drive, compare outputs to model, advance model
    task automatic cycle(input bit req, input bit ckv, input int ckt,
                         input bit fv, input int fp, input bit sd, input int sdt);
        bit exp_valid;
        bit exp_fire;
        bit err_n;
        @(negedge clk);
        bus.alloc_req            = req;
        bus.checkpoint_valid     = ckv;
        bus.checkpoint_tag       = 3'(ckt);
        bus.free_valid           = fv;
        bus.free_preg            = 6'(fp);
        bus.branch_shootdown     = sd;
        bus.shootdown_branch_tag = 3'(sdt);
        #1;
        exp_valid = (m_tail > m_head);
        exp_fire  = req && exp_valid && !sd;
        check("alloc_valid", 32'(bus.alloc_valid), 32'(exp_valid));
        if (exp_valid) check("alloc_preg", 32'(bus.alloc_preg), 32'(log_q[m_head]));
        check("alloc_fire", 32'(bus.alloc_fire), 32'(exp_fire));
        check("free_count", 32'(bus.free_count), 32'(m_tail - m_head));
        check("error", 32'(bus.error), 32'(m_err));

        err_n = 1'b0;
        if (fv) begin
            if (m_tail - m_head == NP) err_n = 1'b1;
            else begin
                log_q.push_back(fp);
                m_tail++;
            end
        end
        if (sd) begin
            if (sdt >= 1 && sdt <= DEPTH && m_cv[sdt-1]) begin
                m_head = m_cp[sdt-1];
                for (int i = sdt - 1; i < DEPTH; i++) m_cv[i] = 1'b0;
            end else err_n = 1'b1;
        end else begin
            if (exp_fire) m_head++;
            if (ckv) begin
                if (ckt >= 1 && ckt <= DEPTH) begin
                    m_cp[ckt-1] = m_head;
                    m_cv[ckt-1] = 1'b1;
                end else err_n = 1'b1;
            end
        end
        m_err = err_n;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset with busy inputs, including a shootdown, which reset must override
    task automatic do_reset(input bit sd);
        @(negedge clk);
        reset                    = 1'b1;
        bus.alloc_req            = 1'b1;
        bus.checkpoint_valid     = 1'b1;
        bus.checkpoint_tag       = 3'd1;
        bus.free_valid           = 1'b1;
        bus.free_preg            = 6'd9;
        bus.branch_shootdown     = sd;
        bus.shootdown_branch_tag = 3'd1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic bit free_allowed();
        int min_h = m_head;
        for (int i = 0; i < DEPTH; i++) if (m_cv[i] && m_cp[i] < min_h) min_h = m_cp[i];
        return (m_tail - min_h) < NP;
    endfunction

    initial begin
        bit rq, ckv, fv, sd;
        int ckt, sdt;

        do_reset(0);

        // Reset state, then drain the list in order
        idle();
        check("rst_preg", 32'(bus.alloc_preg), 32);
        check("rst_count", 32'(bus.free_count), 32);
        check("rst_valid", 32'(bus.alloc_valid), 1);
        check("rst_error", 32'(bus.error), 0);
        for (int i = 0; i < NP - NA; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
            check("issue_order", 32'(bus.alloc_preg), 32'(NA + i));
        end
        idle();
        check("drained_valid", 32'(bus.alloc_valid), 0);
        check("drained_count", 32'(bus.free_count), 0);

        // Free into empty list: no bypass
        cycle(1, 0, 0, 1, 5, 0, 0);
        check("empty_free_fire", 32'(bus.alloc_fire), 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("refill_valid", 32'(bus.alloc_valid), 1);
        check("refill_preg", 32'(bus.alloc_preg), 5);
        check("refill_fire", 32'(bus.alloc_fire), 1);

        // Checkpoint at head 2, allocate 3 more, shoot down
        do_reset(0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        idle();
        check("sd1_count", 32'(bus.free_count), 30);
        check("sd1_preg", 32'(bus.alloc_preg), 34);

        // Nested checkpoints; kill tag 2, then tag 3 is gone, tag 1 still live
        do_reset(0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 2, 0, 0, 0, 0);
        cycle(1, 1, 3, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 2);
        idle();
        check("sd2_preg", 32'(bus.alloc_preg), 34);
        cycle(0, 0, 0, 0, 0, 1, 3);
        idle();
        check("sd3_error", 32'(bus.error), 1);
        check("sd3_preg", 32'(bus.alloc_preg), 34);
        cycle(0, 0, 0, 0, 0, 1, 1);
        idle();
        check("sd1b_preg", 32'(bus.alloc_preg), 33);
        check("sd1b_error", 32'(bus.error), 0);

        // Shootdown with same-cycle alloc and free
        do_reset(0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 7, 1, 1);
        check("sd_fire", 32'(bus.alloc_fire), 0);
        idle();
        check("sd_free_count", 32'(bus.free_count), 32);
        check("sd_free_preg", 32'(bus.alloc_preg), 33);

        // Refill to full, overflow free, then reset mid-shootdown
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 1, i, 0, 0);
        idle();
        check("full_count", 32'(bus.free_count), 64);
        cycle(0, 0, 0, 1, 3, 0, 0);
        idle();
        check("ovf_error", 32'(bus.error), 1);
        check("ovf_count", 32'(bus.free_count), 64);
        do_reset(1);
        idle();
        check("rst2_preg", 32'(bus.alloc_preg), 32);
        check("rst2_count", 32'(bus.free_count), 32);
        check("rst2_error", 32'(bus.error), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                rq  = ($urandom_range(0, 1) == 1);
                ckv = ($urandom_range(0, 4) == 0);
                ckt = ($urandom_range(0, 9) == 0) ? 5 * $urandom_range(0, 1) : $urandom_range(1, 4);
                fv  = ($urandom_range(0, 1) == 1) && free_allowed();
                sd  = ($urandom_range(0, 11) == 0);
                sdt = $urandom_range(0, 5);
                cycle(rq, ckv, ckt, fv, $urandom_range(0, NP - 1), sd, sdt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the rename stage; sits directly upstream of the register alias table.
- Supplies one free physical register per cycle for the rename map write and reclaims physical registers released at commit.
- Checkpoints its allocation pointer per speculative branch tag, so a branch shootdown returns every register allocated under the killed path in one cycle.

Parameters:
- NUM_PREGS, 64, number of physical registers; power of two.
- NUM_AREGS, 32, number of architectural registers; must be < NUM_PREGS.
- MAX_PREDICT_DEPTH, 4, number of branch checkpoint slots.
- MAX_PREDICT_DEPTH_BITS, 3, width of a branch tag; tags run 0..MAX_PREDICT_DEPTH, where 0 means non-speculative.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alloc_req  in  1  rename requests one physical register this cycle.
- alloc_valid  out  1  list is non-empty and alloc_preg is meaningful.
- alloc_preg  out  $clog2(NUM_PREGS)  register at the head of the list; combinational from state.
- alloc_fire  out  1  allocation taken this cycle: alloc_req & alloc_valid & !branch_shootdown.
- checkpoint_valid  in  1  take a head-pointer checkpoint for checkpoint_tag.
- checkpoint_tag  in  MAX_PREDICT_DEPTH_BITS  tag being opened, 1..MAX_PREDICT_DEPTH.
- free_valid  in  1  commit releases a physical register.
- free_preg  in  $clog2(NUM_PREGS)  register being released.
- branch_shootdown  in  1  mispredict recovery request.
- shootdown_branch_tag  in  MAX_PREDICT_DEPTH_BITS  oldest tag killed.
- free_count  out  $clog2(NUM_PREGS)+1  number of entries currently in the list.
- error  out  1  one-cycle pulse on an illegal operation.

Behaviour:
- Storage:
  - Circular buffer of NUM_PREGS entries.
  - head and tail pointers, each $clog2(NUM_PREGS)+1 bits including a wrap bit.
  - free_count = tail - head, computed modulo 2^(width).
  - Empty when head == tail; full when free_count == NUM_PREGS.
- Reset:
  - Buffer entries 0..NUM_PREGS-NUM_AREGS-1 hold pregs NUM_AREGS..NUM_PREGS-1, in ascending order.
  - head = 0; tail = NUM_PREGS-NUM_AREGS; all checkpoint slots invalid.
  - Outputs: error = 0, alloc_fire = 0, alloc_valid = 1, alloc_preg = NUM_AREGS, free_count = NUM_PREGS-NUM_AREGS.
  - Reset overrides every other input in the same cycle, including mid-shootdown.
- Allocate: when alloc_fire is high, head advances by 1 at the edge. Zero-cycle latency: alloc_preg is valid in the same cycle as alloc_req.
- Free:
  - When free_valid is high, free_preg is written at tail and tail advances by 1.
  - A free that arrives while the list is full is dropped and raises error.
  - Frees are never squashed, even when a shootdown occurs in the same cycle.
- Same-cycle alloc and free: both take effect and free_count is unchanged.
  - With the list empty, alloc_valid = 0, so the freed register is visible next cycle; there is no bypass.
- Checkpoint:
  - Slot checkpoint_tag-1 captures head as it stands after this cycle's allocation, if any. Registers allocated in the same cycle therefore belong to the older path.
  - The slot is then marked valid.
  - checkpoint_tag of 0 or greater than MAX_PREDICT_DEPTH raises error and nothing is written.
  - Re-checkpointing a slot that is already valid overwrites it.
- Shootdown, tag t:
  - Legal only if 1 <= t <= MAX_PREDICT_DEPTH and slot t-1 is valid.
  - head is loaded from slot t-1, and slots t-1..MAX_PREDICT_DEPTH-1 are invalidated.
  - alloc_fire is forced to 0 in that cycle.
  - A checkpoint_valid in the same cycle is ignored.
  - On an illegal t, error is raised and there is no state change, except that frees still proceed.
- Restored occupancy stays at most NUM_PREGS as long as every free is legal. The tail is never rolled back.
- No checkpoint release on branch resolve: slots persist until overwritten, shot down or reset.

Test Plan:
- Reset with defaults: alloc_preg = 32, free_count = 32. Hold alloc_req for 32 cycles -> pregs 32..63 issued in order, then alloc_valid = 0 and free_count = 0.
- Empty list, then free_preg = 5 with alloc_req held -> alloc_fire = 0 that cycle; next cycle alloc_valid = 1, alloc_preg = 5, alloc_fire = 1.
- Checkpoint tag 1 after 2 allocations (head = 2), then 3 more allocations, then shootdown tag 1 -> head = 2, free_count = 30, next alloc_preg = 34.
- Checkpoints at tags 1, 2 and 3; shootdown tag 2 -> head restored from slot 1. A subsequent shootdown tag 3 raises error with no head change, while shootdown tag 1 still succeeds.
- Same cycle: shootdown tag 1, alloc_req = 1, free_valid = 1 -> alloc_fire = 0, head restored, tail +1, free_count = restored value + 1.
- Refill to full (64), then one more free -> error pulses, free_count stays 64. Assert reset mid-sequence -> all reset values on the next cycle.
